// File: rtl/adaptor_pkg.sv
// Shared types and helpers for the cache-line <-> memory burst adaptor.
package adaptor_pkg;

    typedef enum logic [2:0] {IDLE, WR, TURN, RD, DONE} adaptor_state_t;
    typedef enum logic [1:0] {NOP, READ, WRITE, EVICT_FILL} adaptor_op_t;

    localparam int unsigned ALIGN_MAX_W = 64;

    // Clear the byte-offset-within-line bits of a byte address.
    function automatic logic [ALIGN_MAX_W-1:0] line_align(input logic [ALIGN_MAX_W-1:0] addr,
                                                          input int unsigned line_w);
        logic [ALIGN_MAX_W-1:0] mask;
        mask = (ALIGN_MAX_W'(1) << $clog2(line_w / 8)) - ALIGN_MAX_W'(1);
        return addr & ~mask;
    endfunction

    // Both requests together mean write back first, then fill.
    function automatic adaptor_op_t decode_op(input logic rd, input logic wr);
        adaptor_op_t op;
        unique case ({rd, wr})
            2'b11:   op = EVICT_FILL;
            2'b10:   op = READ;
            2'b01:   op = WRITE;
            default: op = NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/burst_line_adaptor_if.sv
// Requester + memory-port signal bundle for the burst line adaptor.
interface burst_line_adaptor_if #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64,
    parameter int unsigned ADDR_W  = 32
);
    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic [ADDR_W-1:0]  address_i;
    logic [ADDR_W-1:0]  wb_address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;
    logic [BURST_W-1:0] burst_i;
    logic [BURST_W-1:0] burst_o;
    logic [ADDR_W-1:0]  address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;

    modport slave (
        input  line_i, address_i, wb_address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, wb_address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/burst_line_adaptor.sv
// Splits a cache line into memory beats (write) and reassembles beats into a line (read),
// with a combined write-back-then-fill operation.
module burst_line_adaptor
    import adaptor_pkg::*;
#(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    burst_line_adaptor_if.slave  bus
);

    localparam int unsigned BEATS  = LINE_W / BURST_W;
    localparam int unsigned BEAT_W = $clog2(BEATS);

    if ((LINE_W % BURST_W) != 0 || BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_params
        $error("burst_line_adaptor: LINE_W must be BURST_W times a power of two >= 2");
    end

    adaptor_state_t    state;
    logic [BEAT_W-1:0] beat;
    logic              fill_pending;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] linebuf;
    logic              read_q;
    logic              write_q;
    logic              resp_q;

    adaptor_op_t       op_c;
    logic              last_beat_c;
    logic [ADDR_W-1:0] fill_aligned_c;
    logic [ADDR_W-1:0] wb_aligned_c;

    assign op_c           = decode_op(bus.read_i, bus.write_i);
    assign last_beat_c    = (beat == BEAT_W'(BEATS - 1));
    assign fill_aligned_c = ADDR_W'(line_align(ALIGN_MAX_W'(bus.address_i), LINE_W));
    assign wb_aligned_c   = ADDR_W'(line_align(ALIGN_MAX_W'(bus.wb_address_i), LINE_W));

    // Control and datapath; every output below comes straight from a flop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            beat         <= '0;
            fill_pending <= 1'b0;
            rd_addr      <= '0;
            addr_q       <= '0;
            linebuf      <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            resp_q       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (op_c != NOP) begin
                        beat <= '0;
                    end
                    unique case (op_c)
                        WRITE: begin
                            linebuf      <= bus.line_i;
                            addr_q       <= fill_aligned_c;
                            fill_pending <= 1'b0;
                            write_q      <= 1'b1;
                            state        <= WR;
                        end
                        READ: begin
                            rd_addr      <= fill_aligned_c;
                            addr_q       <= fill_aligned_c;
                            fill_pending <= 1'b0;
                            read_q       <= 1'b1;
                            state        <= RD;
                        end
                        EVICT_FILL: begin
                            linebuf      <= bus.line_i;
                            addr_q       <= wb_aligned_c;
                            rd_addr      <= fill_aligned_c;
                            fill_pending <= 1'b1;
                            write_q      <= 1'b1;
                            state        <= WR;
                        end
                        default: ;
                    endcase
                end
                WR: begin
                    if (bus.resp_i) begin
                        beat <= beat + BEAT_W'(1);
                        if (last_beat_c) begin
                            write_q <= 1'b0;
                            if (fill_pending) begin
                                state <= TURN;
                            end else begin
                                resp_q <= 1'b1;
                                state  <= DONE;
                            end
                        end
                    end
                end
                // Idle gap so memory sees the write command fall before the read rises.
                TURN: begin
                    beat   <= '0;
                    read_q <= 1'b1;
                    addr_q <= rd_addr;
                    state  <= RD;
                end
                RD: begin
                    if (bus.resp_i) begin
                        linebuf[BURST_W*beat +: BURST_W] <= bus.burst_i;
                        beat <= beat + BEAT_W'(1);
                        if (last_beat_c) begin
                            read_q <= 1'b0;
                            resp_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    resp_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.line_o    = linebuf;
    assign bus.burst_o   = linebuf[BURST_W*beat +: BURST_W];
    assign bus.address_o = addr_q;
    assign bus.read_o    = read_q;
    assign bus.write_o   = write_q;
    assign bus.resp_o    = resp_q;

endmodule

// File: tb/tb_burst_line_adaptor.sv
// Randomised bench for burst_line_adaptor: a 256-bit and a 512-bit instance checked cycle by
// cycle against an expected trace built from the op/stall pattern.
module tb_burst_line_adaptor;
    import adaptor_pkg::*;

    localparam int OP_RD = 0;
    localparam int OP_WR = 1;
    localparam int OP_EF = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [511:0] g_line;
    logic [31:0]  g_addr, g_wb;
    logic         g_rd, g_wr, g_resp;
    logic [63:0]  g_burst;
    logic         sel_b;

    burst_line_adaptor_if #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) bus_a ();
    burst_line_adaptor_if #(.LINE_W(512), .BURST_W(64), .ADDR_W(32)) bus_b ();

    burst_line_adaptor #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a));
    burst_line_adaptor #(.LINE_W(512), .BURST_W(64), .ADDR_W(32)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b));

    assign bus_a.line_i       = g_line[255:0];
    assign bus_a.address_i    = g_addr;
    assign bus_a.wb_address_i = g_wb;
    assign bus_a.read_i       = g_rd & ~sel_b;
    assign bus_a.write_i      = g_wr & ~sel_b;
    assign bus_a.resp_i       = g_resp & ~sel_b;
    assign bus_a.burst_i      = g_burst;
    assign bus_b.line_i       = g_line;
    assign bus_b.address_i    = g_addr;
    assign bus_b.wb_address_i = g_wb;
    assign bus_b.read_i       = g_rd & sel_b;
    assign bus_b.write_i      = g_wr & sel_b;
    assign bus_b.resp_i       = g_resp & sel_b;
    assign bus_b.burst_i      = g_burst;

    logic         o_rd, o_wr, o_resp;
    logic [31:0]  o_addr;
    logic [63:0]  o_burst;
    logic [511:0] o_line;
    assign o_rd    = sel_b ? bus_b.read_o    : bus_a.read_o;
    assign o_wr    = sel_b ? bus_b.write_o   : bus_a.write_o;
    assign o_resp  = sel_b ? bus_b.resp_o    : bus_a.resp_o;
    assign o_addr  = sel_b ? bus_b.address_o : bus_a.address_o;
    assign o_burst = sel_b ? bus_b.burst_o   : bus_a.burst_o;
    assign o_line  = sel_b ? bus_b.line_o    : {256'b0, bus_a.line_o};

    typedef struct {
        bit           acc;
        bit           busy;
        int           op;
        logic [511:0] dline;
        logic [31:0]  daddr;
        logic [31:0]  dwb;
        bit           rd;
        bit           wr;
        bit           resp;
        logic [31:0]  addr;
        logic [63:0]  bo;
        logic [511:0] line;
        bit           ri;
        logic [63:0]  bi;
    } cyc_t;

    cyc_t trace[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cur_cyc = 0;

    function automatic void check(string name, logic [511:0] act, logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (trace cycle %0d): got %0h, expected %0h", name, cur_cyc, act, exp);
        end
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [511:0] rand_line(input int lw);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        if (lw == 256) l[511:256] = '0;
        return l;
    endfunction

    // Line-aligned byte address: drop the byte offset within a line.
    function automatic logic [31:0] al(input logic [31:0] a, input int lw);
        return a - (a % (lw / 8));
    endfunction

    function automatic cyc_t blank(input bit busy, input bit ri);
        cyc_t c;
        c.acc = 0; c.busy = busy; c.op = 0; c.dline = '0; c.daddr = '0; c.dwb = '0;
        c.rd = 0; c.wr = 0; c.resp = 0; c.addr = '0; c.bo = '0; c.line = '0;
        c.ri = ri; c.bi = rand64();
        return c;
    endfunction

    task automatic add_idle(input int n, input bit force_ri);
        for (int i = 0; i < n; i++)
            trace.push_back(blank(1'b0, force_ri ? 1'b1 : 1'($urandom_range(1, 0))));
    endtask

    // Expected cycles of one op: accept, write beats, turn, read beats, completion.
    task automatic build_op(input int op, input int lw, input logic [511:0] line,
                            input logic [31:0] addr, input logic [31:0] wb,
                            input int max_stall, input int gap_beat);
        cyc_t c;
        int beats, s;
        logic [511:0] got;
        logic [63:0] d;
        beats = lw / 64;
        got = (op == OP_RD) ? '0 : line;
        c = blank(1'b0, 1'($urandom_range(1, 0)));
        c.acc = 1; c.op = op; c.dline = line; c.daddr = addr; c.dwb = wb;
        trace.push_back(c);
        if (op != OP_RD) begin
            for (int k = 0; k < beats; k++) begin
                s = (k == gap_beat) ? 2 : $urandom_range(max_stall, 0);
                for (int j = 0; j <= s; j++) begin
                    c = blank(1'b1, j == s);
                    c.wr = 1; c.addr = al(op == OP_EF ? wb : addr, lw);
                    c.bo = line[k*64 +: 64];
                    trace.push_back(c);
                end
            end
        end
        if (op == OP_EF) trace.push_back(blank(1'b1, 1'($urandom_range(1, 0))));
        if (op != OP_WR) begin
            for (int k = 0; k < beats; k++) begin
                s = $urandom_range(max_stall, 0);
                for (int j = 0; j <= s; j++) begin
                    d = rand64();
                    c = blank(1'b1, j == s);
                    c.rd = 1; c.addr = al(addr, lw); c.bi = d;
                    if (j == s) got[k*64 +: 64] = d;
                    trace.push_back(c);
                end
            end
        end
        c = blank(1'b1, 1'($urandom_range(1, 0)));
        c.resp = 1; c.line = got;
        trace.push_back(c);
    endtask

    // Drive and compare the queued trace; entered and left at posedge+1.
    task automatic run_trace(input int stop_at, output int resp_idx, output int resp_cnt,
                             output logic [511:0] resp_line);
        cyc_t e;
        resp_idx = -1; resp_cnt = 0; resp_line = '0;
        for (int i = 0; i < trace.size(); i++) begin
            e = trace[i];
            cur_cyc = i;
            g_rd = 1'b0; g_wr = 1'b0;
            if (e.acc) begin
                g_rd = (e.op != OP_WR); g_wr = (e.op != OP_RD);
                g_line = e.dline; g_addr = e.daddr; g_wb = e.dwb;
            end else begin
                g_line = rand_line(512); g_addr = $urandom; g_wb = $urandom;
                if (e.busy) begin
                    g_rd = 1'($urandom_range(1, 0)); g_wr = 1'($urandom_range(1, 0));
                end
            end
            g_resp = e.ri; g_burst = e.bi;
            @(negedge clk);
            check("read_o", 512'(o_rd), 512'(e.rd));
            check("write_o", 512'(o_wr), 512'(e.wr));
            check("resp_o", 512'(o_resp), 512'(e.resp));
            if (e.rd || e.wr) check("address_o", 512'(o_addr), 512'(e.addr));
            if (e.wr) check("burst_o", 512'(o_burst), 512'(e.bo));
            if (e.resp) check("line_o", o_line, e.line);
            if (o_resp) begin
                if (resp_idx < 0) resp_idx = i;
                resp_cnt++;
                resp_line = o_line;
            end
            @(posedge clk);
            #1;
            if (i == stop_at) break;
        end
        trace.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_read_o"}, 512'(o_rd), 512'(0));
        check({tag, "_write_o"}, 512'(o_wr), 512'(0));
        check({tag, "_resp_o"}, 512'(o_resp), 512'(0));
        check({tag, "_address_o"}, 512'(o_addr), 512'(0));
        check({tag, "_line_o"}, o_line, 512'(0));
    endtask

    initial begin
        int ri, rc, op, lw;
        logic [511:0] rl, l;
        logic [63:0] b0, b1, b2, b3;

        reset_n = 1'b0; sel_b = 1'b0;
        g_line = '0; g_addr = '0; g_wb = '0; g_rd = 0; g_wr = 0; g_resp = 0; g_burst = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset_a");
        sel_b = 1'b1; #0;
        check_reset_state("reset_b");
        sel_b = 1'b0;
        reset_n = 1'b1;

        // READ at 0x1234 with no stalls.
        build_op(OP_RD, 256, '0, 32'h0000_1234, '0, 0, -1);
        check("t1_model_align", 512'(trace[1].addr), 512'(32'h0000_1220));
        b0 = trace[1].bi; b1 = trace[2].bi; b2 = trace[3].bi; b3 = trace[4].bi;
        run_trace(-1, ri, rc, rl);
        check("t1_resp_cycle", 512'(ri), 512'(5));
        check("t1_line", rl, {256'b0, b3, b2, b1, b0});

        // WRITE at 0x40 with a two-cycle gap before beat 2.
        l = rand_line(256);
        build_op(OP_WR, 256, l, 32'h40, '0, 0, 2);
        run_trace(-1, ri, rc, rl);
        check("t2_resp_cycle", 512'(ri), 512'(7));
        check("t2_resp_count", 512'(rc), 512'(1));
        check("t2_line", rl, l);

        // EVICT_FILL wb 0x100, fill 0x200.
        build_op(OP_EF, 256, rand_line(256), 32'h200, 32'h100, 0, -1);
        check("t3_model_turn", 512'({trace[5].rd, trace[5].wr}), 512'(0));
        run_trace(-1, ri, rc, rl);
        check("t3_resp_cycle", 512'(ri), 512'(10));

        // Reset right after beat 1 of a READ, then a clean READ.
        build_op(OP_RD, 256, '0, 32'h0000_0380, '0, 0, -1);
        run_trace(2, ri, rc, rl);
        trace.delete();
        reset_n = 1'b0; g_rd = 0; g_wr = 0; g_resp = 0;
        @(posedge clk); #1;
        check_reset_state("t4_midop_reset");
        reset_n = 1'b1;
        build_op(OP_RD, 256, '0, 32'h0000_0455, '0, 0, -1);
        run_trace(-1, ri, rc, rl);
        check("t4_resp_cycle", 512'(ri), 512'(5));

        // Spurious resp_i in IDLE, then back-to-back READs.
        add_idle(3, 1'b1);
        build_op(OP_RD, 256, '0, 32'h0000_0800, '0, 1, -1);
        build_op(OP_RD, 256, '0, 32'h0000_0900, '0, 1, -1);
        run_trace(-1, ri, rc, rl);
        check("t5_resp_count", 512'(rc), 512'(2));

        // Random mix on the 256-bit instance.
        for (int n = 0; n < 40; n++) begin
            add_idle($urandom_range(2, 0), 1'b0);
            op = $urandom_range(2, 0);
            build_op(op, 256, rand_line(256), $urandom, $urandom, 3, -1);
        end
        run_trace(-1, ri, rc, rl);
        check("rand_a_resp_count", 512'(rc), 512'(40));

        // 512-bit instance: 8-beat READ, then a random mix.
        sel_b = 1'b1;
        build_op(OP_RD, 512, '0, 32'h0000_1234, '0, 0, -1);
        check("t6_model_align", 512'(trace[1].addr), 512'(32'h0000_1200));
        run_trace(-1, ri, rc, rl);
        check("t6_resp_cycle", 512'(ri), 512'(9));
        lw = 512;
        for (int n = 0; n < 20; n++) begin
            add_idle($urandom_range(2, 0), 1'b0);
            op = $urandom_range(2, 0);
            build_op(op, lw, rand_line(lw), $urandom, $urandom, 2, -1);
        end
        run_trace(-1, ri, rc, rl);
        check("rand_b_resp_count", 512'(rc), 512'(20));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
